memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL take parameter CPUS, default 2, the number of cache requester pairs; only 2 is supported.
REQ-002 The block SHALL take parameter TIMEOUT, default 64, the maximum BUSY cycles before a grant is aborted.
REQ-003 The block SHALL have port CLK, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports iREN, dREN and dWEN, input, 2 each, per-CPU instruction read, data read and data write requests.
REQ-006 The block SHALL have ports iaddr, daddr and dstore, input, 2x32 each, per-CPU word address and write data.
REQ-007 The block SHALL have ports iwait and dwait, output, 2 each, per-CPU stall; 0 means the transfer completes this cycle.
REQ-008 The block SHALL have ports iload and dload, output, 2x32 each, per-CPU read data.
REQ-009 The block SHALL have ports ramREN and ramWEN, output, 1 each; ramaddr and ramstore, output, 32 each; ramload, input, 32; ramstate, input, 2 (FREE, BUSY, ACCESS, ERROR).
REQ-010 The block SHALL have port err, output, 1, sticky timeout/ERROR flag.

Function
REQ-011 The state machine SHALL have states IDLE and GRANT, held in flops together with owner CPU (1b), owner type (IREAD, DREAD, DWRITE), rr pointer (1b) and a timeout counter.
REQ-012 In IDLE with any request active, the block SHALL register a winner at the next edge and enter GRANT; no RAM strobe is driven in IDLE.
REQ-013 Across CPUs the winner SHALL be chosen round-robin: the CPU equal to rr wins if it requests, otherwise the other CPU wins.
REQ-014 Within one CPU, priority SHALL be dWEN, then dREN, then iREN; dWEN and dREN asserted together is served as a write.
REQ-015 In GRANT the block SHALL drive ramREN/ramWEN, ramaddr and (for writes) ramstore from the owner's latched type and live address/data.
REQ-016 In GRANT with ramstate==ACCESS, the block SHALL combinationally drive the owner's matching wait to 0 for that cycle only, toggle rr to the other CPU, and return to IDLE.
REQ-017 iload and dload for both CPUs SHALL equal ramload at all times; the value is valid only in the completing cycle.
REQ-018 All wait outputs not released per REQ-016 SHALL be 1, including every wait during IDLE.
REQ-019 If the owner deasserts its granted request in GRANT, the block SHALL drop RAM strobes that cycle and return to IDLE with no wait release and no rr change.
REQ-020 In GRANT with ramstate==ERROR, or with the counter reaching TIMEOUT-1, the block SHALL abort to IDLE, set err, toggle rr, and release no wait.
REQ-021 The timeout counter SHALL clear on GRANT entry, increment each GRANT cycle without ACCESS, and saturate at TIMEOUT-1.
REQ-022 Latency SHALL be one idle arbitration cycle plus the RAM access cycles; back-to-back grants are separated by one IDLE cycle.
REQ-023 A request arriving in GRANT SHALL be held pending, not preempting the owner, and arbitrated at the next IDLE.

Reset
REQ-024 While nRST=0 the block SHALL hold state=IDLE, rr=0, owner=0, counter=0 and err=0, with all waits at 1, ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-025 Reset asserted mid-GRANT SHALL drop RAM strobes immediately (asynchronously); the interrupted transfer is not completed.

Verification
REQ-026 Scenario 1: CPU0 iREN, iaddr=0x40, ACCESS on the 3rd GRANT cycle -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait[0]=0 only in cycle 3; rr=1.
REQ-027 Scenario 2: both CPUs assert dREN continuously with rr=0 -> grants alternate CPU0, CPU1, CPU0 with one IDLE cycle between them.
REQ-028 Scenario 3: CPU1 asserts dWEN and dREN, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dwait[1] released once; the read is served next.
REQ-029 Scenario 4: ramstate held BUSY with TIMEOUT=8 -> abort after 8 GRANT cycles; err=1 persists; the wait is never released.
REQ-030 Scenario 5: CPU0 drops iREN in the 2nd GRANT cycle -> strobes 0 that cycle, IDLE next cycle, rr unchanged.
REQ-031 Scenario 6: nRST pulsed low during a GRANT write -> ramWEN=0 immediately; state IDLE, rr=0 and err=0 after release.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - CPU request/response and RAM-side bus bundle for the memory arbiter
interface memory_arbiter_if;
    logic [1:0]        iREN;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  iaddr;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][31:0]  iload;
    logic [1:0][31:0]  dload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;
    logic              err;

    // Arbiter side: services CPU requests and drives the RAM port.
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // Environment side: CPUs and RAM.
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-CPU round-robin arbiter onto a single RAM port with timeout abort
module memory_arbiter #(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.slave   bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] GRANT  = 1'b1;

    localparam logic [1:0] IREAD  = 2'd0;
    localparam logic [1:0] DREAD  = 2'd1;
    localparam logic [1:0] DWRITE = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [0:0]    state;
    logic          owner;
    logic [1:0]    otype;
    logic          rr;
    logic [CW-1:0] cnt;
    logic          err_q;

    logic [CPUS-1:0] req;
    logic            win_cpu;
    logic [1:0]      win_type;
    logic            owner_req;
    logic            active;
    logic            done;
    logic            abort;

    // Arbitration: rr CPU first if it asks, then write > read > fetch within the CPU.
    always_comb begin
        req      = '0;
        for (int i = 0; i < CPUS; i++) begin
            req[i] = bus.iREN[i] | bus.dREN[i] | bus.dWEN[i];
        end
        win_cpu  = req[rr] ? rr : ~rr;
        if (bus.dWEN[win_cpu])
            win_type = DWRITE;
        else if (bus.dREN[win_cpu])
            win_type = DREAD;
        else
            win_type = IREAD;
    end

    // Grant qualification: a dropped request kills the transfer before ACCESS/abort are considered.
    always_comb begin
        case (otype)
            DWRITE:  owner_req = bus.dWEN[owner];
            DREAD:   owner_req = bus.dREN[owner];
            default: owner_req = bus.iREN[owner];
        endcase
        active = (state == GRANT) && owner_req;
        done   = active && (bus.ramstate == RS_ACCESS);
        abort  = active && !done && ((bus.ramstate == RS_ERROR) || (cnt == CNT_MAX));
    end

    // RAM port and per-CPU stalls; everything idles at zero strobes / all waits high.
    always_comb begin
        bus.ramREN   = active && (otype != DWRITE);
        bus.ramWEN   = active && (otype == DWRITE);
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (active)
            bus.ramaddr = (otype == IREAD) ? bus.iaddr[owner] : bus.daddr[owner];
        if (active && (otype == DWRITE))
            bus.ramstore = bus.dstore[owner];
        bus.iwait = '1;
        bus.dwait = '1;
        if (done) begin
            if (otype == IREAD)
                bus.iwait[owner] = 1'b0;
            else
                bus.dwait[owner] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            bus.iload[i] = bus.ramload;
            bus.dload[i] = bus.ramload;
        end
        bus.err = err_q;
    end

    // State, owner, round-robin pointer, timeout counter and sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= 1'b0;
            otype <= IREAD;
            rr    <= 1'b0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        owner <= win_cpu;
                        otype <= win_type;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (done) begin
                        state <= IDLE;
                        rr    <= ~owner;
                    end else if (abort) begin
                        state <= IDLE;
                        rr    <= ~owner;
                        err_q <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt   <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    memory_arbiter_if bus();

    memory_arbiter #(.CPUS(2), .TIMEOUT(8)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.iREN = '0;
        bus.dREN = '0;
        bus.dWEN = '0;
    endtask

    logic [1:0]  s2_dwait [6];
    logic        s2_ren   [6];
    logic [31:0] s2_addr  [6];

    initial begin
        rst_n        = 1'b0;
        clear_reqs();
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = 2'd0;

        // Reset state
        @(negedge clk);
        check("rst_iwait",   32'(bus.iwait),   32'h3);
        check("rst_dwait",   32'(bus.dwait),   32'h3);
        check("rst_ramren",  32'(bus.ramREN),  32'h0);
        check("rst_ramwen",  32'(bus.ramWEN),  32'h0);
        check("rst_ramaddr", bus.ramaddr,      32'h0);
        check("rst_err",     32'(bus.err),     32'h0);
        next_cycle();
        rst_n = 1'b1;

        // Scenario 1: CPU0 fetch, ACCESS on 3rd GRANT cycle
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        bus.ramstate = 2'd1;
        @(negedge clk);
        check("s1_idle_ren", 32'(bus.ramREN), 32'h0);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                bus.ramstate = 2'd2;
                bus.ramload  = 32'h12345678;
            end
            @(negedge clk);
            check($sformatf("s1_c%0d_ren", k),  32'(bus.ramREN), 32'h1);
            check($sformatf("s1_c%0d_addr", k), bus.ramaddr,     32'h40);
            check($sformatf("s1_c%0d_iwait", k), 32'(bus.iwait), (k == 3) ? 32'h2 : 32'h3);
            next_cycle();
        end
        check("s1_iload0", bus.iload[0], 32'h12345678);
        check("s1_dload1", bus.dload[1], 32'h12345678);
        clear_reqs();
        bus.ramstate = 2'd0;
        @(negedge clk);
        check("s1_after_ren", 32'(bus.ramREN), 32'h0);
        check("s1_after_iw",  32'(bus.iwait),  32'h3);
        check("s1_rr",        32'(dut.rr),     32'h1);

        // Scenario 2: both CPUs read continuously from rr=0
        next_cycle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        s2_dwait = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
        s2_ren   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        s2_addr  = '{32'h0, 32'h200, 32'h0, 32'h300, 32'h0, 32'h200};
        bus.daddr[0] = 32'h200;
        bus.daddr[1] = 32'h300;
        bus.dREN     = 2'b11;
        bus.ramstate = 2'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("s2_c%0d_dwait", k), 32'(bus.dwait), 32'(s2_dwait[k]));
            check($sformatf("s2_c%0d_ren", k),   32'(bus.ramREN), 32'(s2_ren[k]));
            check($sformatf("s2_c%0d_addr", k),  bus.ramaddr,     s2_addr[k]);
            next_cycle();
        end
        clear_reqs();

        // Scenario 3: CPU1 write+read together, write first then read
        bus.dWEN[1]   = 1'b1;
        bus.dREN[1]   = 1'b1;
        bus.daddr[1]  = 32'h100;
        bus.dstore[1] = 32'hDEADBEEF;
        bus.ramstate  = 2'd1;
        @(negedge clk);
        check("s3_idle_wen", 32'(bus.ramWEN), 32'h0);
        next_cycle();
        @(negedge clk);
        check("s3_c1_wen",   32'(bus.ramWEN), 32'h1);
        check("s3_c1_ren",   32'(bus.ramREN), 32'h0);
        check("s3_c1_store", bus.ramstore,    32'hDEADBEEF);
        check("s3_c1_addr",  bus.ramaddr,     32'h100);
        check("s3_c1_dwait", 32'(bus.dwait),  32'h3);
        next_cycle();
        bus.ramstate = 2'd2;
        @(negedge clk);
        check("s3_c2_dwait", 32'(bus.dwait),  32'h1);
        check("s3_c2_wen",   32'(bus.ramWEN), 32'h1);
        next_cycle();
        bus.dWEN[1] = 1'b0;
        @(negedge clk);
        check("s3_idle2_dwait", 32'(bus.dwait),  32'h3);
        check("s3_idle2_ren",   32'(bus.ramREN), 32'h0);
        next_cycle();
        @(negedge clk);
        check("s3_rd_ren",   32'(bus.ramREN), 32'h1);
        check("s3_rd_wen",   32'(bus.ramWEN), 32'h0);
        check("s3_rd_store", bus.ramstore,    32'h0);
        check("s3_rd_dwait", 32'(bus.dwait),  32'h1);
        next_cycle();
        clear_reqs();

        // Scenario 4: RAM stuck BUSY, abort after 8 GRANT cycles
        bus.dREN[0]  = 1'b1;
        bus.daddr[0] = 32'h500;
        bus.ramstate = 2'd1;
        next_cycle();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("s4_c%0d_ren", k),   32'(bus.ramREN), 32'h1);
            check($sformatf("s4_c%0d_dwait", k), 32'(bus.dwait),  32'h3);
            check($sformatf("s4_c%0d_err", k),   32'(bus.err),    32'h0);
            next_cycle();
        end
        clear_reqs();
        @(negedge clk);
        check("s4_abort_ren",   32'(bus.ramREN), 32'h0);
        check("s4_abort_err",   32'(bus.err),    32'h1);
        check("s4_abort_dwait", 32'(bus.dwait),  32'h3);
        next_cycle();
        @(negedge clk);
        check("s4_err_sticky", 32'(bus.err), 32'h1);
        check("s4_rr",         32'(dut.rr),  32'h1);

        // Scenario 5: CPU0 drops fetch in 2nd GRANT cycle
        next_cycle();
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h80;
        next_cycle();
        @(negedge clk);
        check("s5_c1_ren", 32'(bus.ramREN), 32'h1);
        next_cycle();
        bus.iREN[0] = 1'b0;
        @(negedge clk);
        check("s5_c2_ren",   32'(bus.ramREN), 32'h0);
        check("s5_c2_iwait", 32'(bus.iwait),  32'h3);
        next_cycle();
        @(negedge clk);
        check("s5_state", 32'(dut.state), 32'h0);
        check("s5_rr",    32'(dut.rr),    32'h1);

        // Scenario 6: reset pulse in the middle of a GRANT write
        next_cycle();
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h44;
        bus.dstore[0] = 32'h55;
        next_cycle();
        @(negedge clk);
        check("s6_wen_before", 32'(bus.ramWEN), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_wen_async",   32'(bus.ramWEN), 32'h0);
        check("s6_store_async", bus.ramstore,    32'h0);
        clear_reqs();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_state", 32'(dut.state), 32'h0);
        check("s6_rr",    32'(dut.rr),    32'h0);
        check("s6_err",   32'(bus.err),   32'h0);
        check("s6_dwait", 32'(bus.dwait), 32'h3);

        // ERROR from RAM aborts without releasing the wait
        next_cycle();
        bus.iREN[1]  = 1'b1;
        bus.iaddr[1] = 32'h90;
        bus.ramstate = 2'd3;
        next_cycle();
        @(negedge clk);
        check("e_c1_iwait", 32'(bus.iwait),  32'h3);
        check("e_c1_ren",   32'(bus.ramREN), 32'h1);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check("e_err", 32'(bus.err), 32'h1);
        check("e_rr",  32'(dut.rr),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
